// File: rtl/reg_file_store_pkg.sv
// Shared constants and types for the general register file storage array.
// Holds the default geometry, the control-state encoding and the clear-sequence start index.
package reg_file_store_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = 5;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        CLEAR = 2'd2
    } state_e;

    // R0 has no storage, so the clear sequence starts at R1.
    localparam logic [RF_ADDR_W-1:0] CLR_FIRST = 5'd1;

endpackage

// File: rtl/reg_file_store_wr_decode.sv
// One-hot write-enable decoder for the register array.
// Bit 0 is always low because R0 is a constant zero with no flops.
module reg_file_wr_decode #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] we_o
);

    // Decode the effective address into a single write strobe.
    always_comb begin
        we_o = '0;
        if (en_i) begin
            we_o[addr_i] = 1'b1;
        end else begin
            we_o = '0;
        end
        we_o[0] = 1'b0;
    end

endmodule

// File: rtl/reg_file_store.sv
// 32 x 32-bit general register file storage with valid/ready write port and a
// sequenced bulk clear of R1..R31; all contents are driven flat to the read muxes.
module reg_file_store
    import reg_file_store_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic                         clr_req_i,
    output logic                         clr_busy_o,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                wr_ready_q, clr_busy_q;
    logic [DATA_W-1:0]   regs_q [1:NUM_REGS-1];

    logic                clearing_s;
    logic                wr_acc_s;
    logic                we_en_s;
    logic [ADDR_W-1:0]   eff_addr_s;
    logic [DATA_W-1:0]   wr_mux_s;
    logic [NUM_REGS-1:0] we_s;

    // Next-state and clear-counter logic.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            INIT: begin
                state_d = IDLE;
            end
            IDLE: begin
                if (clr_req_i) begin
                    state_d   = CLEAR;
                    clr_cnt_d = ADDR_W'(CLR_FIRST);
                end else begin
                    state_d   = IDLE;
                end
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d   = INIT;
                clr_cnt_d = '0;
            end
        endcase
    end

    // State register; handshake outputs are registered decodes of the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= INIT;
            clr_cnt_q  <= '0;
            wr_ready_q <= 1'b0;
            clr_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wr_ready_q <= (state_d == IDLE);
            clr_busy_q <= (state_d == CLEAR);
        end
    end

    // wr_ready_q is only high in IDLE, so acceptance never overlaps a clear step.
    assign clearing_s = (state_q == CLEAR);
    assign wr_acc_s   = wr_valid_i & wr_ready_q;
    assign we_en_s    = clearing_s | wr_acc_s;
    assign eff_addr_s = clearing_s ? clr_cnt_q : wr_addr_i;
    assign wr_mux_s   = clearing_s ? {DATA_W{1'b0}} : wr_data_i;

    reg_file_wr_decode #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_wr_decode (
        .addr_i (eff_addr_s),
        .en_i   (we_en_s),
        .we_o   (we_s)
    );

    // Register storage for R1..R(NUM_REGS-1).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k < NUM_REGS; k++) begin
                if (we_s[k]) begin
                    regs_q[k] <= wr_mux_s;
                end
            end
        end
    end

    assign regs_flat_o[DATA_W-1:0] = {DATA_W{1'b0}};

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign wr_ready_o = wr_ready_q;
    assign clr_busy_o = clr_busy_q;

endmodule

// File: tb/tb_reg_file_store.sv
// Randomized self-checking bench for reg_file_store against a register-array
// model with a countdown for the pending clear.
module tb_reg_file_store;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              wr_valid_i = 1'b0;
    logic              wr_ready_o;
    logic [AW-1:0]     wr_addr_i = '0;
    logic [DW-1:0]     wr_data_i = '0;
    logic              clr_req_i = 1'b0;
    logic              clr_busy_o;
    logic [NR*DW-1:0]  regs_flat_o;

    logic [DW-1:0] m_regs [NR];
    bit            m_init;
    int            m_clr_left;
    int            n_checks = 0;
    int            n_fail = 0;

    reg_file_store dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_valid_i  (wr_valid_i),
        .wr_ready_o  (wr_ready_o),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .clr_req_i   (clr_req_i),
        .clr_busy_o  (clr_busy_o),
        .regs_flat_o (regs_flat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NR; k++) m_regs[k] = '0;
        m_init     = 1'b0;
        m_clr_left = 0;
    endfunction

    // Behaviour at one rising edge, from the inputs held across it.
    function automatic void model_edge();
        if (!rst_ni) return;
        if (!m_init) begin
            m_init = 1'b1;
        end else if (m_clr_left > 0) begin
            m_regs[NR - m_clr_left] = '0;
            m_clr_left--;
        end else begin
            if (wr_valid_i && wr_addr_i != 0) m_regs[wr_addr_i] = wr_data_i;
            if (clr_req_i) m_clr_left = NR - 1;
        end
    endfunction

    task automatic compare_all();
        check("wr_ready", {31'd0, wr_ready_o}, {31'd0, (m_init && m_clr_left == 0)});
        check("clr_busy", {31'd0, clr_busy_o}, {31'd0, (m_clr_left > 0)});
        for (int k = 0; k < NR; k++)
            check($sformatf("R%0d", k), regs_flat_o[k*DW +: DW], m_regs[k]);
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic c);
        @(negedge clk_i);
        wr_valid_i = v;
        wr_addr_i  = a;
        wr_data_i  = d;
        clr_req_i  = c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int g;

        // Reset then idle.
        model_reset();
        #1;
        compare_all();
        repeat (3) step();
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("ready_before_first_edge", {31'd0, wr_ready_o}, 32'd0);
        step();

        // Basic write.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        step();
        check("R5_slice", regs_flat_o[191:160], 32'hDEADBEEF);

        // R0 discard.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
        check("R0_handshake", {31'd0, wr_ready_o}, 32'd1);
        step();
        check("R0_slice", regs_flat_o[31:0], 32'd0);

        // Fill then full clear.
        for (int k = 1; k < NR; k++) begin
            drive(1'b1, AW'(k), 32'(32'h11 * k), 1'b0);
            step();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        cnt = 0;
        while (clr_busy_o === 1'b1 && cnt < 40) begin
            cnt++;
            step();
        end
        check("clr_busy_cycles", cnt, 32'd31);

        // Write stalled by clear.
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        step();
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0);
        g = 0;
        while (wr_ready_o !== 1'b1 && g < 40) begin
            step();
            g++;
        end
        check("stall_bounded", {31'd0, (g < 40)}, 32'd1);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        step();
        check("R7_after_stall", regs_flat_o[7*DW +: DW], 32'hA5A5A5A5);

        // Simultaneous write and clear request.
        drive(1'b1, 5'd3, 32'hC3C30003, 1'b1);
        step();
        check("R3_written", regs_flat_o[3*DW +: DW], 32'hC3C30003);
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        step();
        step();
        step();
        check("R3_cleared", regs_flat_o[3*DW +: DW], 32'd0);
        repeat (28) step();
        check("ready_after_sim_clear", {31'd0, wr_ready_o}, 32'd1);

        // Reset mid-clear.
        drive(1'b1, 5'd20, 32'h12345678, 1'b0);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b1);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        repeat (10) step();
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("flat_zero_on_reset", {31'd0, (|regs_flat_o)}, 32'd0);
        step();
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("init_not_ready", {31'd0, wr_ready_o}, 32'd0);
        step();

        // Random traffic.
        repeat (400) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)),
                  32'($urandom), 1'($urandom_range(0, 24) == 0));
            step();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0);
        repeat (35) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_store.md
# reg_file_store

Storage array for the 32 x 32-bit general register file. It accepts one write per cycle from the write-back stage over a valid/ready handshake and supports a sequenced bulk clear. It drives all register contents as a flattened 1024-bit bus, `regs_flat`, which feeds the register-file read multiplexers directly. R0 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 32, register width.
- NUM_REGS, 32, register count; must be a power of two.
- ADDR_W, 5, log2(NUM_REGS).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset. All state is cleared immediately on assertion.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  block can accept a write this cycle.
- wr_addr  in  ADDR_W  destination register index.
- wr_data  in  DATA_W  write data.
- clr_req  in  1  single-cycle pulse requesting a bulk clear of R1..R31.
- clr_busy  out  1  bulk clear in progress.
- regs_flat  out  NUM_REGS*DATA_W  register k occupies bits [32k+31:32k]. A read-mux select of k yields register k.

## Operation
- State machine states: INIT, IDLE, CLEAR.
  - INIT: entered on reset. Transitions to IDLE unconditionally on the first clock edge after rst_n deasserts.
  - IDLE: wr_ready=1, clr_busy=0.
  - CLEAR: wr_ready=0, clr_busy=1.
- wr_ready and clr_busy are registered outputs that decode the state.
- Write acceptance:
  - A write is accepted when wr_valid && wr_ready.
  - The register at wr_addr takes wr_data at that clock edge.
  - A write to wr_addr=0 is accepted (the handshake completes) but is discarded. Register 0 is constant 0 and has no flops.
- Clear sequence:
  - In IDLE, clr_req=1 moves the block to CLEAR and loads a 5-bit clear counter with 1.
  - Each cycle in CLEAR zeroes the register at the counter index, then increments the counter.
  - When the counter reaches 31 and that register is cleared, the block returns to IDLE.
  - The sequence always clears 31 registers over 31 cycles.
- clr_req is ignored outside IDLE. It is not queued.
- Simultaneous write acceptance and clr_req in IDLE: the write completes at that edge, and CLEAR starts at the same edge. The written register is therefore zeroed later in the sequence.
- wr_valid held during CLEAR is not accepted. The requester must hold wr_valid and its write data stable until wr_ready returns.
- Reset mid-clear: the block goes immediately to INIT with all registers zero. The partial sequence is abandoned.

## Timing
- Reset values:
  - regs_flat: all 0.
  - wr_ready: 0.
  - clr_busy: 0.
  - state: INIT.
  - clear counter: 0.
- wr_ready rises on the first rising edge after rst_n deasserts.
- Write latency: a write accepted at edge t is visible on regs_flat immediately after edge t. There is no internal forwarding; read-after-write bypass is the responsibility of the read path.
- Clear timing, for clr_req sampled at edge t:
  - clr_busy=1 and wr_ready=0 from just after t.
  - Register k (k = 1..31) reads zero after edge t+k.
  - clr_busy=0 and wr_ready=1 just after t+31.
- regs_flat comes directly from the flops, with no combinational path from inputs.

## Structure
- Shared package: DATA_W, NUM_REGS, ADDR_W, the state enum {INIT, IDLE, CLEAR}, and the constant CLR_FIRST=1.
- One natural sub-module, `reg_file_wr_decode`: a one-hot write-enable decoder. Its inputs are the effective address (clear counter in CLEAR, wr_addr otherwise) and the enable. Its output is a NUM_REGS-bit write enable with bit 0 forced to 0.
- The data mux selects 0 during CLEAR and wr_data otherwise.

## Test plan
- Reset then idle:
  - Hold rst_n=0 for 3 cycles, then release. Required: regs_flat=0 throughout and wr_ready=0 until the first edge after release, then 1.
- Basic write:
  - Write 0xDEADBEEF to R5. Required: regs_flat[191:160]=0xDEADBEEF after the accepting edge; all other slices unchanged.
- R0 discard:
  - Write 0xFFFFFFFF to R0 with wr_valid=1. Required: handshake completes (wr_ready=1) and regs_flat[31:0] stays 0.
- Full clear:
  - Write 0x11*k to every Rk, then pulse clr_req. Required: clr_busy high for exactly 31 cycles, R1 zero after edge +1, R31 zero after edge +31, wr_ready back high at +31.
- Write stalled by clear:
  - Assert wr_valid with R7=0xA5A5A5A5 one cycle into CLEAR and hold it. Required: not accepted until wr_ready returns, then R7=0xA5A5A5A5 and it is not cleared.
- Reset mid-clear plus simultaneous events:
  - Start a clear, then assert rst_n=0 at cycle +10. Required: all registers 0 immediately and state INIT.
  - Separately, assert a write to R3 together with clr_req. Required: R3 takes the data, then is zeroed after edge +3.
